// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone bundle shared by the initiators and the slave of wb_arbiter2.
interface if_wb #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_m;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_s;
  logic            ack;
  logic            stall;

  modport master (output cyc, stb, we, adr, dat_m, sel, input dat_s, ack, stall);
  modport slave  (input cyc, stb, we, adr, dat_m, sel, output dat_s, ack, stall);
endinterface

// File: rtl/wb_arbiter2.sv
// Two-initiator, one-slave pipelined Wishbone arbiter with bus lock for the
// whole cyc, round-robin or fixed priority, and a stall/outstanding watchdog.
module wb_arbiter2 #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255,
  parameter int TW         = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_wb.slave        m0,
  if_wb.slave        m1,
  if_wb.master       sbus,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

  localparam logic [TW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  state_t        state;
  logic          last;
  logic [TW-1:0] wdog;
  logic          outst;
  logic          own_idx;
  logic          own_cyc;
  logic          oth_cyc;

  always_comb begin
    own_idx = (state == OWN1);
    own_cyc = own_idx ? m1.cyc : m0.cyc;
    oth_cyc = own_idx ? m0.cyc : m1.cyc;
  end

  always_comb begin
    sbus.cyc   = 1'b0;
    sbus.stb   = 1'b0;
    sbus.we    = 1'b0;
    sbus.adr   = '0;
    sbus.dat_m = '0;
    sbus.sel   = '0;
    m0.ack     = 1'b0;
    m0.stall   = 1'b1;
    m0.dat_s   = '0;
    m1.ack     = 1'b0;
    m1.stall   = 1'b1;
    m1.dat_s   = '0;
    case (state)
      OWN0: begin
        sbus.cyc   = m0.cyc;
        sbus.stb   = m0.stb;
        sbus.we    = m0.we;
        sbus.adr   = m0.adr;
        sbus.dat_m = m0.dat_m;
        sbus.sel   = m0.sel;
        m0.ack     = sbus.ack;
        m0.stall   = sbus.stall;
        m0.dat_s   = sbus.dat_s;
      end
      OWN1: begin
        sbus.cyc   = m1.cyc;
        sbus.stb   = m1.stb;
        sbus.we    = m1.we;
        sbus.adr   = m1.adr;
        sbus.dat_m = m1.dat_m;
        sbus.sel   = m1.sel;
        m1.ack     = sbus.ack;
        m1.stall   = sbus.stall;
        m1.dat_s   = sbus.dat_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      grant   <= '0;
      timeout <= 1'b0;
      last    <= 1'b1;
      wdog    <= '0;
      outst   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          wdog  <= '0;
          outst <= 1'b0;
          if (m0.cyc && m1.cyc) begin
            if (FIXED_PRIO != 0 || last) begin
              state <= OWN0;
              grant <= 2'b01;
            end else begin
              state <= OWN1;
              grant <= 2'b10;
            end
          end else if (m0.cyc) begin
            state <= OWN0;
            grant <= 2'b01;
          end else if (m1.cyc) begin
            state <= OWN1;
            grant <= 2'b10;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc) begin
            // Hand over directly when the other side is already waiting.
            last  <= own_idx;
            wdog  <= '0;
            outst <= 1'b0;
            if (oth_cyc) begin
              state <= own_idx ? OWN0 : OWN1;
              grant <= own_idx ? 2'b01 : 2'b10;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end else if (sbus.ack) begin
            wdog  <= '0;
            outst <= sbus.stb && !sbus.stall;
          end else if (sbus.stb || outst) begin
            outst <= outst || (sbus.stb && !sbus.stall);
            // Abort on the cycle the count would reach TIMEOUT; an ack wins above.
            if (TIMEOUT != 0 && wdog == WD_LAST) begin
              state   <= ABORT;
              grant   <= '0;
              timeout <= 1'b1;
              last    <= own_idx;
              wdog    <= '0;
              outst   <= 1'b0;
            end else if (wdog != '1) begin
              wdog <= wdog + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          wdog  <= '0;
          outst <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: forwarding, arbitration order, bus lock,
// watchdog abort, reset recovery and serialized traffic against a memory model.
module tb_wb_arbiter2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant, fgrant;
  logic       timeout, ftimeout;
  int         checks = 0;
  int         failures = 0;
  int         ack0_cnt = 0;
  int         ack1_cnt = 0;

  if_wb m0b ();
  if_wb m1b ();
  if_wb sb ();
  if_wb fm0 ();
  if_wb fm1 ();
  if_wb fsb ();

  wb_arbiter2 #(.FIXED_PRIO(0), .TIMEOUT(16), .TW(8)) dut (
    .clk_i(clk), .rst_i(rst), .m0(m0b), .m1(m1b), .sbus(sb),
    .grant(grant), .timeout(timeout)
  );

  wb_arbiter2 #(.FIXED_PRIO(1), .TIMEOUT(16), .TW(8)) dut_fp (
    .clk_i(clk), .rst_i(rst), .m0(fm0), .m1(fm1), .sbus(fsb),
    .grant(fgrant), .timeout(ftimeout)
  );

  always #5 clk = ~clk;

  // The fixed-priority instance sees the same requests against a silent slave.
  assign fm0.cyc = m0b.cyc;  assign fm0.stb = m0b.stb;  assign fm0.we = m0b.we;
  assign fm0.adr = m0b.adr;  assign fm0.dat_m = m0b.dat_m;  assign fm0.sel = m0b.sel;
  assign fm1.cyc = m1b.cyc;  assign fm1.stb = m1b.stb;  assign fm1.we = m1b.we;
  assign fm1.adr = m1b.adr;  assign fm1.dat_m = m1b.dat_m;  assign fm1.sel = m1b.sel;
  assign fsb.ack = 1'b0;
  assign fsb.stall = 1'b0;
  assign fsb.dat_s = '0;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] wr_adr, wr_dat;
  int          wr_cnt;
  bit          resp_en = 1'b1;

  assign sb.stall = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 + i;
      sb.ack  <= 1'b0;
      sb.dat_s <= '0;
      wr_cnt  <= 0;
    end else begin
      sb.ack   <= resp_en && sb.cyc && sb.stb && !sb.stall;
      sb.dat_s <= mem[sb.adr[5:2]];
      if (sb.cyc && sb.stb && !sb.stall && sb.we) begin
        mem[sb.adr[5:2]] <= sb.dat_m;
        wr_adr <= sb.adr;
        wr_dat <= sb.dat_m;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m0b.ack) ack0_cnt++;
    if (m1b.ack) ack1_cnt++;
    checks++;
    assert (grant !== 2'b11 && !(m0b.ack && grant !== 2'b01) && !(m1b.ack && grant !== 2'b10))
    else begin
      failures++;
      $error("FAIL mon_route: observed grant=%b ack0=%b ack1=%b expected one-hot grant with owner-only ack",
             grant, m0b.ack, m1b.ack);
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: observed no finish expected finish before limit");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0b.cyc = cyc; m0b.stb = stb; m0b.we = we; m0b.adr = adr; m0b.dat_m = dat; m0b.sel = 4'hF;
    end else begin
      m1b.cyc = cyc; m1b.stb = stb; m1b.we = we; m1b.adr = adr; m1b.dat_m = dat; m1b.sel = 4'hF;
    end
  endtask

  function automatic logic stall_of(input int m);
    return (m == 0) ? m0b.stall : m1b.stall;
  endfunction

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0b.ack : m1b.ack;
  endfunction

  function automatic logic [31:0] dat_of(input int m);
    return (m == 0) ? m0b.dat_s : m1b.dat_s;
  endfunction

  task automatic ref_init();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA500_0000 + i;
  endtask

  task automatic xfer(input int m, input logic we, input int idx, input logic [31:0] wdat, input int n);
    int w;
    drive(m, 1'b1, 1'b1, we, 32'(idx) << 2, wdat);
    w = 0;
    while (stall_of(m) && w < 50) begin tick(); w++; end
    if (w >= 50) begin
      check($sformatf("x%0d_grant_wait", n), 32'(stall_of(m)), 32'd0);
      drive(m, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      return;
    end
    tick();
    drive(m, 1'b1, 1'b0, we, 32'(idx) << 2, wdat);
    w = 0;
    while (!ack_of(m) && w < 20) begin tick(); w++; end
    check($sformatf("x%0d_ack", n), 32'(ack_of(m)), 32'd1);
    if (!we) check($sformatf("x%0d_rdata", n), dat_of(m), ref_mem[idx]);
    else ref_mem[idx] = wdat;
    tick();
    drive(m, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  initial begin
    int a0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    ref_init();
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_sbus_cyc", 32'(sb.cyc), 32'd0);
    check("rst_stall", {30'd0, m0b.stall, m1b.stall}, 32'd3);
    check("rst_ack", {30'd0, m0b.ack, m1b.ack}, 32'd0);
    rst = 1'b0;
    tick();

    // Single write from m0.
    a0 = ack0_cnt;
    drive(0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    check("t1_grant_c0", 32'(grant), 32'd0);
    check("t1_stall_c0", 32'(m0b.stall), 32'd1);
    tick();
    check("t1_grant", 32'(grant), 32'd1);
    check("t1_fwd_ctl", {29'd0, sb.cyc, sb.stb, sb.we}, 32'd7);
    check("t1_fwd_adr", sb.adr, 32'h100);
    check("t1_fwd_dat", sb.dat_m, 32'hDEAD_BEEF);
    check("t1_m1_stall", 32'(m1b.stall), 32'd1);
    tick();
    check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t1_wr_adr", wr_adr, 32'h100);
    check("t1_wr_dat", wr_dat, 32'hDEAD_BEEF);
    check("t1_ack", 32'(m0b.ack), 32'd1);
    ref_mem[0] = 32'hDEAD_BEEF;
    drive(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    check("t1_ack_count", 32'(ack0_cnt - a0), 32'd1);

    // m0 locks the bus over four pipelined reads while m1 waits.
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, '0);
    tick();
    check("t3_grant0", 32'(grant), 32'd1);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h3C, '0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b1, 1'b0, 32'h10 + 32'(4 * k), '0);
      check($sformatf("t3_m1_stall_%0d", k), 32'(m1b.stall), 32'd1);
      tick();
      check($sformatf("t3_ack_%0d", k), 32'(m0b.ack), 32'd1);
      check($sformatf("t3_rdata_%0d", k), m0b.dat_s, ref_mem[4 + k]);
    end
    drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("t3_m1_stall_tail", 32'(m1b.stall), 32'd1);
    tick();
    check("t3_grant_hold", 32'(grant), 32'd1);
    check("t3_m1_stall_last", 32'(m1b.stall), 32'd1);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    check("t3_handover", 32'(grant), 32'd2);
    check("t3_m1_unstall", 32'(m1b.stall), 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();

    // Slave never acks: abort after 16 counted cycles.
    resp_en = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h20, '0);
    tick();
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("t4_pre_%0d", k), {29'd0, timeout, grant}, 32'd1);
      tick();
    end
    check("t4_timeout", 32'(timeout), 32'd1);
    check("t4_sbus_cyc", 32'(sb.cyc), 32'd0);
    check("t4_grant", 32'(grant), 32'd0);
    check("t4_owner_stall", 32'(m0b.stall), 32'd1);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    check("t4_pulse_end", 32'(timeout), 32'd0);
    resp_en = 1'b1;

    // Reset while m1 owns the bus with a request outstanding.
    resp_en = 1'b0;
    drive(1, 1'b1, 1'b1, 1'b0, 32'h24, '0);
    tick();
    tick();
    tick();
    check("t5_grant_pre", 32'(grant), 32'd2);
    rst = 1'b1;
    tick();
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_sbus_cyc", 32'(sb.cyc), 32'd0);
    check("t5_acks", {30'd0, m0b.ack, m1b.ack}, 32'd0);
    check("t5_m1_stall", 32'(m1b.stall), 32'd1);
    rst = 1'b0;
    resp_en = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    ref_init();
    tick();

    // Four simultaneous requests: alternate under RR, always m0 under fixed priority.
    for (int r = 0; r < 4; r++) begin
      drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
      tick();
      check($sformatf("t2_rr_%0d", r), 32'(grant), (r % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("t2_fp_%0d", r), 32'(fgrant), 32'd1);
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
    end

    // Serialized random traffic from both initiators against the reference memory.
    for (int n = 0; n < 24; n++) begin
      xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           $urandom, n);
    end
    check("t6_idle", 32'(grant), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
